// File: rtl/scratch_stack_ctrl.sv
// Scratch RAM initiator: owns the stack pointer and sequences push/pop/store/load/SP-load
// requests through an IDLE -> ACCESS -> RESP handshake with a one-cycle DONE pulse.
module scratch_stack_ctrl #(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned SP_RESET = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_PUSH,
    input  logic              REQ_POP,
    input  logic              REQ_ST,
    input  logic              REQ_LD,
    input  logic              REQ_SPLD,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [DATA_W-1:0] SCR_DATA_OUT,
    output logic [ADDR_W-1:0] SCR_ADDR,
    output logic [DATA_W-1:0] SCR_DATA_IN,
    output logic              SCR_WE,
    output logic [DATA_W-1:0] RDATA,
    output logic [ADDR_W-1:0] SP_OUT,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVF,
    output logic              UNF
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    localparam logic [2:0] OpPush = 3'd0;
    localparam logic [2:0] OpPop  = 3'd1;
    localparam logic [2:0] OpSt   = 3'd2;
    localparam logic [2:0] OpLd   = 3'd3;
    localparam logic [2:0] OpSpld = 3'd4;

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    // Set when a push hits a full stack or a pop hits an empty one.
    logic              rej_q, rej_d;

    logic any_req;
    assign any_req = REQ_PUSH | REQ_POP | REQ_ST | REQ_LD | REQ_SPLD;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        rej_d   = rej_q;
        case (state_q)
            StIdle: begin
                // The DONE cycle still counts as busy, so requests wait for it to clear.
                if (any_req && !done_q) begin
                    state_d = StAccess;
                    wdata_d = WDATA;
                    rej_d   = 1'b0;
                    if (REQ_SPLD) begin
                        op_d   = OpSpld;
                        addr_d = ADDR_IN;
                    end else if (REQ_PUSH) begin
                        op_d   = OpPush;
                        addr_d = sp_q - 1'b1;
                        rej_d  = (cnt_q == CNT_W'(DEPTH));
                        we_d   = (cnt_q != CNT_W'(DEPTH));
                    end else if (REQ_POP) begin
                        op_d   = OpPop;
                        addr_d = sp_q;
                        rej_d  = (cnt_q == '0);
                    end else if (REQ_ST) begin
                        op_d   = OpSt;
                        addr_d = ADDR_IN;
                        we_d   = 1'b1;
                    end else begin
                        op_d   = OpLd;
                        addr_d = ADDR_IN;
                    end
                end
            end
            StAccess: begin
                state_d = StResp;
                if (op_q == OpPush && !rej_q) begin
                    sp_d  = sp_q - 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end else if (op_q == OpPop && !rej_q) begin
                    sp_d  = sp_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end else if (op_q == OpSpld) begin
                    sp_d  = addr_q;
                    cnt_d = '0;
                end
            end
            StResp: begin
                state_d = StIdle;
                done_d  = 1'b1;
                ovf_d   = (op_q == OpPush) && rej_q;
                unf_d   = (op_q == OpPop) && rej_q;
                if ((op_q == OpPop && !rej_q) || op_q == OpLd) begin
                    rdata_d = SCR_DATA_OUT;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            op_q    <= OpPush;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sp_q    <= ADDR_W'(SP_RESET);
            cnt_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            rej_q   <= rej_d;
        end
    end

    assign SCR_ADDR    = addr_q;
    assign SCR_DATA_IN = wdata_q;
    assign SCR_WE      = we_q;
    assign RDATA       = rdata_q;
    assign SP_OUT      = sp_q;
    assign BUSY        = (state_q != StIdle) | done_q;
    assign DONE        = done_q;
    assign OVF         = ovf_q;
    assign UNF         = unf_q;

endmodule
